// File: rtl/pg_prefix_pipe.sv
// Two-stage valid/ready pipeline: stage 1 forms per-bit generate/propagate,
// stage 2 resolves carries with a Kogge-Stone prefix network and registers the sum.
module pg_prefix_pipe #(
  parameter int WIDTH         = 16,
  parameter bit PG_RESET_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             gg,
  output logic             gp
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             v1;
  logic [WIDTH-1:0] g1, p1, x1;
  logic             c1;
  logic             adv1, adv2;

  logic [WIDTH-1:0] gk [LEVELS+1];
  logic [WIDTH-1:0] pk [LEVELS+1];
  logic [WIDTH:0]   c;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  // Gated by rst_n so upstream sees no acceptance while reset is held.
  assign in_ready = rst_n && adv1;

  // NOTE: state uses non-blocking assignments; datapath registers only clear
  // when PG_RESET_ZERO is set, the valid flags always clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      if (PG_RESET_ZERO) begin
        g1 <= '0;
        p1 <= '0;
        x1 <= '0;
        c1 <= 1'b0;
      end
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        g1 <= a & b;
        p1 <= mode ? (a ^ b) : (a | b);
        x1 <= a ^ b;
        c1 <= cin;
      end
    end
  end

  // Group (G,P) over [i:0] after LEVELS doubling steps; carries then fold in cin.
  // NOTE: every variable here gets a full default before any conditional write.
  always_comb begin
    gk[0] = g1;
    pk[0] = p1;
    for (int l = 0; l < LEVELS; l++) begin
      gk[l+1] = gk[l];
      pk[l+1] = pk[l];
      for (int i = (1 << l); i < WIDTH; i++) begin
        gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
        pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
      end
    end
    c[0] = c1;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = gk[LEVELS][i] | (pk[LEVELS][i] & c1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      if (PG_RESET_ZERO) begin
        g    <= '0;
        p    <= '0;
        sum  <= '0;
        cout <= 1'b0;
        gg   <= 1'b0;
        gp   <= 1'b0;
      end
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        g    <= g1;
        p    <= p1;
        sum  <= x1 ^ c[WIDTH-1:0];
        cout <= c[WIDTH];
        gg   <= gk[LEVELS][WIDTH-1];
        gp   <= &p1;
      end
    end
  end

endmodule

// File: doc/pg_prefix_pipe.md
PG_PREFIX_PIPE -- requirements
Module: pg_prefix_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the operand width (legal values 2..64).
REQ-002 The block SHALL have parameter PG_RESET_ZERO, default 1; when 1, all datapath output registers clear on reset, and when 0 only the valid flags clear.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port mode, input, 1 bit: propagate definition, where 0 = a OR b and 1 = a XOR b.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result registers hold a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts a result.
REQ-012 The block SHALL have ports g and p, output, WIDTH bits each: per-bit generate and propagate.
REQ-013 The block SHALL have port sum, output, WIDTH bits: a + b + cin, modulo 2^WIDTH.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 The block SHALL have ports gg and gp, output, 1 bit each: group generate (carry out of the word with cin=0) and group propagate (AND of all p bits).

Function
REQ-016 The block SHALL be a two-stage pipeline: stage 1 registers g = a AND b, p (per the captured mode), x = a XOR b, and cin; stage 2 registers sum, cout, gg, gp, and forwards g and p.
REQ-017 Latency SHALL be exactly 2 cycles from an accepted input (in_valid and in_ready both high at an edge) to out_valid, when out_ready is held high.
REQ-018 Full throughput SHALL be one result per cycle when out_ready is held high.
REQ-019 Carries SHALL be computed by a parallel-prefix (Kogge-Stone or Sklansky) network over the stage-1 g/p, using c[i+1] = g[i] OR (p[i] AND c[i]) with c[0] = cin; results are identical for both modes.
REQ-020 sum[i] SHALL equal x[i] XOR c[i] irrespective of mode; p as output reflects mode.
REQ-021 Stage-2 advance SHALL occur when stage 2 is empty or out_ready is high; stage-1 advance SHALL occur when stage 1 is empty or stage 2 advances.
REQ-022 in_ready SHALL be high when stage 1 is empty or stage 1 advances this cycle; a combinational path from out_ready to in_ready is permitted.
REQ-023 While out_valid is high and out_ready is low, all outputs SHALL hold stable.
REQ-024 Simultaneous accept and emit in the same cycle SHALL lose no result; ordering SHALL be strictly FIFO.
REQ-025 mode and cin SHALL be sampled only at accept; later changes SHALL NOT affect in-flight results.
REQ-026 Inputs presented while in_ready is low SHALL be ignored.

Reset
REQ-027 On rst_n low, both stage valid flags SHALL clear immediately, so out_valid = 0.
REQ-028 On rst_n low, with PG_RESET_ZERO = 1, g, p, sum, cout, gg and gp SHALL all clear to 0.
REQ-029 While rst_n is low, in_ready SHALL be 0.
REQ-030 in_ready SHALL return to 1 in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard in-flight data; no stale result SHALL appear after reset.

Verification
REQ-032 WIDTH=16, a=0xFFFF, b=0x0001, cin=0, mode=1 -> 2 cycles later: sum=0x0000, cout=1, g=0x0001, p=0xFFFE, gg=1, gp=0.
REQ-033 Same operands with mode=0 -> p=0xFFFF, gp=1; sum, cout, g and gg unchanged.
REQ-034 a=0x1234, b=0x4321, cin=1, mode=1 -> sum=0x5556, cout=0, g=0x0220, p=0x5115, gg=0.
REQ-035 out_ready=0, offer 3 back-to-back operand sets -> exactly 2 accepted, in_ready=0, first result held stable; raise out_ready -> 3rd accepted, all 3 emitted in order on consecutive cycles.
REQ-036 Stream 100 random operand sets with out_ready=1 -> one result per cycle after 2-cycle fill, each matching a reference model.
REQ-037 Assert rst_n low with both stages full -> out_valid=0 and outputs=0 asynchronously; after release, no old result appears and the first new result has latency 2.
